// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo_if : Z80 I/O read bus between CPU side and the RX FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic [7:0]  dout;
  logic        oe;

  modport master (
    output a, iorq_n, rd_n,
    input  dout, oe
  );

  modport slave (
    input  a, iorq_n, rd_n,
    output dout, oe
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : UART receive FIFO on Z80 ports 0x143B (data) / 0x133B (status)
// Optional RTS hysteresis enabled by macro UART_RX_RTS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int RTS_HIGH_WATER = 12,
  parameter int RTS_LOW_WATER  = 4
) (
  input  wire          clk,
  input  wire          rst_n,
  uart_rx_fifo_if.slave bus,
  input  wire  [7:0]   rx_data,
  input  wire          rx_valid,
  input  wire          tx_busy,
  output logic         uart_rts,
  output logic         overflow
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL = c_DEPTH[DEPTH_LOG2:0];

  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [1:0]            r_rd_sync_n;
  logic                  r_rd_prev;
  logic                  r_rx_seen;
  logic                  r_st_seen;

  logic w_rd_cyc;
  logic w_sel_rx;
  logic w_sel_st;
  logic w_full;
  logic w_empty;
  logic w_rd_synced;
  logic w_fall;
  logic w_do_pop;
  logic w_do_push;
  logic w_ovf_set;
  logic w_st_clr;

  assign w_rd_cyc = ~bus.iorq_n & ~bus.rd_n;
  assign w_sel_rx = w_rd_cyc & (bus.a == 16'h143B);
  assign w_sel_st = w_rd_cyc & (bus.a == 16'h133B);
  assign bus.oe   = w_sel_rx | w_sel_st;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  always_comb begin
    bus.dout = 8'h00;
    if (w_sel_rx) begin
      bus.dout = w_empty ? 8'h00 : r_mem[r_rptr];
    end else if (w_sel_st) begin
      bus.dout = {4'b0000, r_overflow, w_full, tx_busy, ~w_empty};
    end
  end

  // The bus cycle is synchronised inverted so the idle level resets to 1.
  assign w_rd_synced = ~r_rd_sync_n[1];
  assign w_fall      = r_rd_prev & ~w_rd_synced;
  assign w_do_pop    = w_fall & r_rx_seen & ~w_empty;
  assign w_st_clr    = w_fall & r_st_seen;
  // A pop in the same clock frees a slot, so a push into a full FIFO is kept.
  assign w_do_push   = rx_valid & (~w_full | w_do_pop);
  assign w_ovf_set   = rx_valid & w_full & ~w_do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sync_n <= 2'b11;
      r_rd_prev   <= 1'b0;
      r_rx_seen   <= 1'b0;
      r_st_seen   <= 1'b0;
    end else begin
      r_rd_sync_n <= {r_rd_sync_n[0], ~w_rd_cyc};
      r_rd_prev   <= w_rd_synced;
      if (w_fall) begin
        r_rx_seen <= 1'b0;
        r_st_seen <= 1'b0;
      end else if (w_rd_synced) begin
        r_rx_seen <= r_rx_seen | w_sel_rx;
        r_st_seen <= r_st_seen | w_sel_st;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)     r_overflow <= 1'b1;
      else if (w_st_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= rx_data;
  end

  assign overflow = r_overflow;

`ifdef UART_RX_RTS_EN
  localparam logic [DEPTH_LOG2:0] c_RTS_HI = RTS_HIGH_WATER[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] c_RTS_LO = RTS_LOW_WATER[DEPTH_LOG2:0];
  logic r_rts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rts <= 1'b0;
    end else if (r_count >= c_RTS_HI) begin
      r_rts <= 1'b1;
    end else if (r_count <= c_RTS_LO) begin
      r_rts <= 1'b0;
    end
  end

  assign uart_rts = r_rts;
`else
  assign uart_rts = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : directed self-checking bench for uart_rx_fifo
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  wire        uart_rts;
  wire        overflow;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .uart_rts (uart_rts),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] c_RX = 16'h143B;
  localparam logic [15:0] c_ST = 16'h133B;

  task automatic bus_idle();
    bus.a      = 16'h0000;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Full bus read: held 3 clocks, then idle long enough for the pop to land.
  task automatic bus_read(input logic [15:0] addr, output logic [7:0] d, output logic o);
    @(negedge clk);
    bus.a      = addr;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    d = bus.dout;
    o = bus.oe;
    @(negedge clk);
    bus_idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       o;
    do_reset();
    checks++;
    if (bus.oe !== 1'b0) begin errors++; $display("FAIL reset_oe_idle: got %b want 0", bus.oe); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", d); end
    checks++;
    if (o !== 1'b1) begin errors++; $display("FAIL reset_status_oe: got %b want 1", o); end
    checks++;
    if (uart_rts !== 1'b0) begin errors++; $display("FAIL reset_rts: got %b want 0", uart_rts); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       o;
    push(8'h41);
    push(8'h42);
    tx_busy = 1'b1;
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL basic_status_busy: got %h want 03", d); end
    tx_busy = 1'b0;
    bus_read(c_RX, d, o);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL basic_read0: got %h want 41", d); end
    bus_read(c_RX, d, o);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL basic_read1: got %h want 42", d); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL basic_status_empty: got %h want 00", d); end
  endtask

  task automatic test_hold();
    logic [7:0] d;
    logic       o;
    int         bad = 0;
    push(8'h55);
    push(8'h66);
    @(negedge clk);
    bus.a      = c_RX;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.dout !== 8'h55) begin
        errors++;
        $display("FAIL hold_head_cycle%0d: got %h want 55", i, bus.dout);
      end
    end
    @(negedge clk);
    bus_idle();
    repeat (5) @(negedge clk);
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL hold_one_pop_status: got %h want 01", d); end
    bus_read(c_RX, d, o);
    checks++;
    if (d !== 8'h66) begin errors++; $display("FAIL hold_next_head: got %h want 66", d); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL hold_empty_status: got %h want 00", d); end
    if (bad != 0) errors++;
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       o;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i));
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h0D) begin errors++; $display("FAIL ovf_full_status: got %h want 0d", d); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_status: got %b want 0", overflow); end
    push(8'h20);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_reset_again: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      bus_read(c_RX, d, o);
      checks++;
      if (d !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, d, 8'(i)); end
    end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL ovf_status_after_drain: got %h want 08", d); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_status_cleared: got %h want 00", d); end
  endtask

  task automatic test_rts();
    logic [7:0] d;
    logic       o;
    logic       exp_hi;
`ifdef UART_RX_RTS_EN
    exp_hi = 1'b1;
`else
    exp_hi = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 11; i++) push(8'h80 + 8'(i));
    repeat (2) @(negedge clk);
    checks++;
    if (uart_rts !== 1'b0) begin errors++; $display("FAIL rts_at11: got %b want 0", uart_rts); end
    push(8'h8B);
    repeat (2) @(negedge clk);
    checks++;
    if (uart_rts !== exp_hi) begin errors++; $display("FAIL rts_at12: got %b want %b", uart_rts, exp_hi); end
    for (int i = 0; i < 7; i++) bus_read(c_RX, d, o);
    @(negedge clk);
    checks++;
    if (uart_rts !== exp_hi) begin errors++; $display("FAIL rts_at5: got %b want %b", uart_rts, exp_hi); end
    checks++;
    if (d !== 8'h86) begin errors++; $display("FAIL rts_pop_data: got %h want 86", d); end
    bus_read(c_RX, d, o);
    @(negedge clk);
    checks++;
    if (uart_rts !== 1'b0) begin errors++; $display("FAIL rts_at4: got %b want 0", uart_rts); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       o;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    @(negedge clk);
    bus.a      = c_RX;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.dout !== 8'hA0) begin errors++; $display("FAIL b2b_head: got %h want a0", bus.dout); end
    @(negedge clk);
    bus_idle();
    // Pop pulse lands on the third rising edge after the bus goes idle.
    repeat (2) @(negedge clk);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %b want 0", overflow); end
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL b2b_still_full: got %h want 05", d); end
    push(8'h99);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_drop_sets_ovf: got %b want 1", overflow); end
    @(negedge clk);
    bus.a      = c_RX;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.dout !== 8'hA1) begin errors++; $display("FAIL b2b_head_a1: got %h want a1", bus.dout); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: got %h want 00", bus.dout); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
    checks++;
    if (bus.oe !== 1'b1) begin errors++; $display("FAIL rst_mid_oe: got %b want 1", bus.oe); end
    @(negedge clk);
    bus_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(c_ST, d, o);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_after_status: got %h want 00", d); end
    push(8'h77);
    repeat (6) @(negedge clk);
    bus_read(c_RX, d, o);
    checks++;
    if (d !== 8'h77) begin errors++; $display("FAIL rst_no_stale_pop: got %h want 77", d); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_rts();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
